// File: rtl/psg_volume_sequencer.sv
// Shares one attenuation lookup across all PSG channels by scanning them one per clock after each sample tick.
// Optional sticky start-while-busy flag: define PSG_SEQ_OVERRUN_EN to add the overrun port.
module psg_volume_sequencer #(
    parameter int CHANNELS     = 4,
    parameter int CONTROL_BITS = 4,
    parameter int VOLUME_BITS  = 14,
    parameter int OUT_BITS     = VOLUME_BITS + $clog2(CHANNELS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [CHANNELS-1:0]              chan_in,
    input  logic [CHANNELS*CONTROL_BITS-1:0] chan_att,
    output logic                             lut_in,
    output logic [CONTROL_BITS-1:0]          lut_control,
    input  logic [VOLUME_BITS-1:0]           lut_volume,
    output logic [OUT_BITS-1:0]              sample,
    output logic                             sample_valid,
    output logic                             busy
`ifdef PSG_SEQ_OVERRUN_EN
    ,
    output logic                             overrun
`endif
);

    localparam int IDX_BITS = $clog2(CHANNELS);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(CHANNELS - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                            state_q, state_d;
    logic [IDX_BITS-1:0]               idx_q, idx_d;
    logic [OUT_BITS-1:0]               acc_q, acc_d;
    logic [CHANNELS-1:0]               snap_in_q, snap_in_d;
    logic [CHANNELS*CONTROL_BITS-1:0]  snap_att_q, snap_att_d;
    logic [OUT_BITS-1:0]               sample_q, sample_d;
    logic                              valid_q, valid_d;
`ifdef PSG_SEQ_OVERRUN_EN
    logic                              overrun_q, overrun_d;
`endif

    // State register.
    // NOTE: the snapshot is a handful of flops, not a RAM, so it is reset along with everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            acc_q      <= '0;
            snap_in_q  <= '0;
            snap_att_q <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
`ifdef PSG_SEQ_OVERRUN_EN
            overrun_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            snap_in_q  <= snap_in_d;
            snap_att_q <= snap_att_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
`ifdef PSG_SEQ_OVERRUN_EN
            overrun_q  <= overrun_d;
`endif
        end
    end

    // Next-state and datapath.
    always_comb begin
        // NOTE: hold-value defaults on every path keep this block free of inferred latches.
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        snap_in_d  = snap_in_q;
        snap_att_d = snap_att_q;
        sample_d   = sample_q;
        valid_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    snap_in_d  = chan_in;
                    snap_att_d = chan_att;
                    idx_d      = '0;
                    acc_d      = '0;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                acc_d = acc_q + OUT_BITS'(lut_volume);
                if (idx_q == LAST_IDX) begin
                    sample_d = acc_d;
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef PSG_SEQ_OVERRUN_EN
        overrun_d = overrun_q;
        if (start && state_q == SCAN) overrun_d = 1'b1;
        // The pulse that ends a pass acknowledges the flag; it overrides a same-edge set.
        if (valid_q) overrun_d = 1'b0;
`endif
    end

    // Outputs, decoded from registers only; IDLE presents a silent lookup request.
    always_comb begin
        busy        = (state_q == SCAN);
        lut_in      = 1'b0;
        lut_control = '1;
        if (state_q == SCAN) begin
            lut_in      = snap_in_q[idx_q];
            lut_control = snap_att_q[int'(idx_q)*CONTROL_BITS +: CONTROL_BITS];
        end
    end

    assign sample       = sample_q;
    assign sample_valid = valid_q;
`ifdef PSG_SEQ_OVERRUN_EN
    assign overrun      = overrun_q;
`endif

endmodule

// File: tb/tb_psg_volume_sequencer.sv
// Scoreboard bench for psg_volume_sequencer with a behavioural 2 dB-per-step attenuation lookup attached.
module tb_psg_volume_sequencer;

    localparam int CH = 4;
    localparam int CB = 4;
    localparam int VB = 14;
    localparam int OB = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [CH-1:0]   chan_in = '0;
    logic [CH*CB-1:0] chan_att = '0;
    logic            lut_in;
    logic [CB-1:0]   lut_control;
    logic [VB-1:0]   lut_volume;
    logic [OB-1:0]   sample;
    logic            sample_valid;
    logic            busy;
`ifdef PSG_SEQ_OVERRUN_EN
    logic            overrun;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    psg_volume_sequencer #(
        .CHANNELS(CH), .CONTROL_BITS(CB), .VOLUME_BITS(VB), .OUT_BITS(OB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .chan_in(chan_in), .chan_att(chan_att),
        .lut_in(lut_in), .lut_control(lut_control), .lut_volume(lut_volume),
        .sample(sample), .sample_valid(sample_valid), .busy(busy)
`ifdef PSG_SEQ_OVERRUN_EN
        , .overrun(overrun)
`endif
    );

    // 16383 * 10^(-k/10), truncated; step 15 is silence.
    function automatic int vol_of(input logic [3:0] k);
        case (k)
            4'd0:  return 16383;  4'd1:  return 13013;
            4'd2:  return 10336;  4'd3:  return 8210;
            4'd4:  return 6522;   4'd5:  return 5180;
            4'd6:  return 4115;   4'd7:  return 3268;
            4'd8:  return 2596;   4'd9:  return 2062;
            4'd10: return 1638;   4'd11: return 1301;
            4'd12: return 1033;   4'd13: return 821;
            4'd14: return 652;    default: return 0;
        endcase
    endfunction

    assign lut_volume = lut_in ? VB'(vol_of(lut_control)) : '0;

    function automatic int model_mix(input logic [CH-1:0] in, input logic [CH*CB-1:0] att);
        int s = 0;
        for (int i = 0; i < CH; i++)
            if (in[i]) s += vol_of(att[i*CB +: CB]);
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every valid pulse must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #2;
        if (rst_n && sample_valid) begin
            if (exp_q.size() == 0) check("spurious_valid", 1, 0);
            else check("sample", 32'(sample), 32'(exp_q.pop_front()));
        end
    end

    task automatic run_pass(input logic [CH-1:0] in, input logic [CH*CB-1:0] att,
                            input int mod_at, input logic [CH-1:0] mod_in);
        int n = 0;
        int nb = 0;
        exp_q.push_back(model_mix(in, att));
        chan_in  = in;
        chan_att = att;
        start    = 1'b1;
        tick();
        start = 1'b0;
        while (!sample_valid && n < 20) begin
            if (n == mod_at) chan_in = mod_in;
            if (n < CH) begin
                check("scan_lut_in", 32'(lut_in), 32'(in[n]));
                check("scan_lut_ctl", 32'(lut_control), 32'(att[n*CB +: CB]));
            end
            if (busy) nb++;
            tick();
            n++;
        end
        check("latency", n, CH);
        check("busy_cycles", nb, CH);
        tick();
        check("valid_width", 32'(sample_valid), 0);
    endtask

    initial begin
        int t, last, got, bad_lut, bad_hold;
        logic [OB-1:0] held;

        #12;
        check("rst_sample", 32'(sample), 0);
        check("rst_valid", 32'(sample_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_lut_in", 32'(lut_in), 0);
        check("rst_lut_ctl", 32'(lut_control), 32'hF);
        rst_n = 1'b1;
        tick();

        // Full scale on every channel.
        run_pass(4'b1111, 16'h0000, -1, '0);
        // Mixed attenuations: ch3=14, ch2=15, ch1=2, ch0=0.
        run_pass(4'b1111, 16'hEF20, -1, '0);
        // Inputs change mid-pass; the snapshot must shield the result.
        run_pass(4'b0101, 16'h0000, 1, 4'b1111);
        run_pass(4'b1010, 16'h7531, -1, '0);

        // start held high: a pass every CH+1 cycles.
        chan_in  = 4'b1111;
        chan_att = '0;
        repeat (3) exp_q.push_back(model_mix(4'b1111, 16'h0000));
        start = 1'b1;
        tick();
        t = 0; last = 0; got = 0;
        while (got < 3 && t < 40) begin
            if (sample_valid) begin
                got++;
                if (got > 1) check("interval", t - last, CH + 1);
                last = t;
`ifdef PSG_SEQ_OVERRUN_EN
                if (got == 1) check("overrun_set", 32'(overrun), 1);
`endif
                if (got == 3) start = 1'b0;
            end
            tick();
            t++;
        end
        start = 1'b0;
        check("passes", got, 3);
`ifdef PSG_SEQ_OVERRUN_EN
        check("overrun_clr", 32'(overrun), 0);
`endif
        tick();
        check("queue_drained", exp_q.size(), 0);

        // Reset in the 3rd SCAN cycle aborts the pass.
        chan_in  = 4'b1111;
        chan_att = '0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("abort_sample", 32'(sample), 0);
        check("abort_valid", 32'(sample_valid), 0);
        check("abort_busy", 32'(busy), 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_pass(4'b1111, 16'hFFFF, -1, '0);

        // Idle: silent lookup request and held sample.
        run_pass(4'b0111, 16'h0000, -1, '0);
        held = sample;
        check("held_value", 32'(held), 32'(model_mix(4'b0111, 16'h0000)));
        bad_lut = 0; bad_hold = 0;
        for (int i = 0; i < 100; i++) begin
            chan_in  = 4'($urandom);
            chan_att = 16'($urandom);
            if (!busy && (lut_in !== 1'b0 || lut_control !== 4'hF)) bad_lut++;
            if (sample !== held || busy !== 1'b0) bad_hold++;
            tick();
        end
        check("idle_lut", bad_lut, 0);
        check("idle_hold", bad_hold, 0);
        check("final_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
